// File: rtl/vector_partial_reducer.sv
// Reduces per-lane (acc, ai) partials through a pipelined adder tree, accumulates
// beats until a last-flagged one, adds the group bias once and hands the result out.
module vector_partial_reducer #(
  parameter int unsigned MUL_PER_FEATURE = 4,
  parameter int unsigned BIAS_PRECISION  = 32,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       ce,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic                                       in_last,
  input  logic [BIAS_PRECISION*MUL_PER_FEATURE-1:0]  acc_in,
  input  logic [BIAS_PRECISION*MUL_PER_FEATURE-1:0]  ai_in,
  input  logic [BIAS_PRECISION-1:0]                  bias_in,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [BIAS_PRECISION-1:0]                  out_acc,
  output logic [BIAS_PRECISION-1:0]                  out_ai,
  output logic [COUNT_WIDTH-1:0]                     out_count
);

  localparam int unsigned BP     = BIAS_PRECISION;
  localparam int unsigned N      = MUL_PER_FEATURE;
  localparam int unsigned LEVELS = $clog2(N);

  typedef enum logic [0:0] {
    ST_FIRST,
    ST_ACCUM
  } state_e;

  logic adv;
  logic [BP-1:0] lane_acc [N];
  logic [BP-1:0] lane_ai  [N];

  logic          t_valid;
  logic          t_last;
  logic [BP-1:0] t_acc;
  logic [BP-1:0] t_ai;
  logic [BP-1:0] t_bias;

  state_e               state_q, state_d;
  logic [BP-1:0]        sum_acc_q, sum_acc_d;
  logic [BP-1:0]        sum_ai_q, sum_ai_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [BP-1:0]        out_acc_q, out_acc_d;
  logic [BP-1:0]        out_ai_q, out_ai_d;
  logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                 beat;
  logic                 done;

  assign adv      = ce && (!out_valid_q || out_ready);
  assign in_ready = adv && rst;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      lane_acc[i] = acc_in[i*BP +: BP];
      lane_ai[i]  = ai_in[i*BP +: BP];
    end
  end

  if (LEVELS == 0) begin : g_notree
    assign t_valid = in_valid;
    assign t_last  = in_last;
    assign t_acc   = lane_acc[0];
    assign t_ai    = lane_ai[0];
    assign t_bias  = bias_in;
  end else begin : g_tree
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int unsigned W = N >> (l + 1);
      logic [BP-1:0] src_acc [2*W];
      logic [BP-1:0] src_ai  [2*W];
      logic          src_valid;
      logic          src_last;
      logic [BP-1:0] src_bias;
      logic [BP-1:0] acc_q [W];
      logic [BP-1:0] ai_q  [W];
      logic          valid_q;
      logic          last_q;
      logic [BP-1:0] bias_q;

      if (l == 0) begin : g_src
        assign src_acc   = lane_acc;
        assign src_ai    = lane_ai;
        assign src_valid = in_valid;
        assign src_last  = in_last;
        assign src_bias  = bias_in;
      end else begin : g_src
        assign src_acc   = g_lvl[l-1].acc_q;
        assign src_ai    = g_lvl[l-1].ai_q;
        assign src_valid = g_lvl[l-1].valid_q;
        assign src_last  = g_lvl[l-1].last_q;
        assign src_bias  = g_lvl[l-1].bias_q;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          bias_q  <= '0;
          for (int unsigned j = 0; j < W; j++) begin
            acc_q[j] <= '0;
            ai_q[j]  <= '0;
          end
        end else if (adv) begin
          valid_q <= src_valid;
          last_q  <= src_last;
          bias_q  <= src_bias;
          for (int unsigned j = 0; j < W; j++) begin
            acc_q[j] <= src_acc[2*j] + src_acc[2*j+1];
            ai_q[j]  <= src_ai[2*j] + src_ai[2*j+1];
          end
        end
      end
    end

    assign t_valid = g_lvl[LEVELS-1].valid_q;
    assign t_last  = g_lvl[LEVELS-1].last_q;
    assign t_acc   = g_lvl[LEVELS-1].acc_q[0];
    assign t_ai    = g_lvl[LEVELS-1].ai_q[0];
    assign t_bias  = g_lvl[LEVELS-1].bias_q;
  end

  assign beat = adv && t_valid;
  assign done = beat && t_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  // The emit step is folded into the last beat: the completed sum goes straight
  // to the output registers while the FSM re-arms for the next group.
  always_comb begin
    state_d = state_q;
    if (beat) begin
      state_d = t_last ? ST_FIRST : ST_ACCUM;
    end
  end

  always_comb begin
    if (state_q == ST_FIRST) begin
      sum_acc_d = t_bias + t_acc;
      sum_ai_d  = t_ai;
      cnt_d     = COUNT_WIDTH'(1);
    end else begin
      sum_acc_d = sum_acc_q + t_acc;
      sum_ai_d  = sum_ai_q + t_ai;
      cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_ai_d    = out_ai_q;
    out_count_d = out_count_q;
    if (adv) begin
      if (done) begin
        out_valid_d = 1'b1;
        out_acc_d   = sum_acc_d;
        out_ai_d    = sum_ai_d;
        out_count_d = cnt_d;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_acc_q <= '0;
      sum_ai_q  <= '0;
      cnt_q     <= '0;
    end else if (beat && !t_last) begin
      sum_acc_q <= sum_acc_d;
      sum_ai_q  <= sum_ai_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ai_q    <= '0;
      out_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_ai_q    <= out_ai_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ai    = out_ai_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_vector_partial_reducer.sv
// Bench for vector_partial_reducer: directed scenarios plus randomized groups
// checked against a group-level reference model and an ordered result queue.
module tb_vector_partial_reducer;

  localparam int unsigned N  = 4;
  localparam int unsigned BP = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;
  logic [N*BP-1:0] acc_in = '0;
  logic [N*BP-1:0] ai_in = '0;
  logic [BP-1:0] bias_in = '0;
  logic          in_ready;
  logic          out_valid;
  logic [BP-1:0] out_acc;
  logic [BP-1:0] out_ai;
  logic [CW-1:0] out_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [BP-1:0] acc;
    logic [BP-1:0] ai;
    int unsigned   cnt;
  } res_t;

  res_t          exp_q[$];
  logic [BP-1:0] m_acc = '0;
  logic [BP-1:0] m_ai = '0;
  int unsigned   m_cnt = 0;
  bit            m_open = 1'b0;
  int unsigned   n_pushed = 0;
  int unsigned   n_popped = 0;
  bit            rnd_ready = 1'b0;

  always #5 clk = ~clk;

  vector_partial_reducer #(
    .MUL_PER_FEATURE(N),
    .BIAS_PRECISION (BP),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .acc_in   (acc_in),
    .ai_in    (ai_in),
    .bias_in  (bias_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_ai   (out_ai),
    .out_count(out_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [BP-1:0] lane_sum(input logic [N*BP-1:0] v);
    logic [BP-1:0] s;
    s = '0;
    for (int i = 0; i < int'(N); i++) s = s + v[i*BP +: BP];
    return s;
  endfunction

  function automatic logic [N*BP-1:0] rand_vec();
    logic [N*BP-1:0] v;
    for (int i = 0; i < int'(N); i++) begin
      case ($urandom_range(0, 7))
        0:       v[i*BP +: BP] = '1;
        1:       v[i*BP +: BP] = 32'h8000_0000;
        default: v[i*BP +: BP] = $urandom;
      endcase
    end
    return v;
  endfunction

  // Reference: group sums from the accepted-beat stream, results in order.
  always @(negedge clk) begin : mon
    res_t e;
    if (rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_acc", 64'(out_acc), 64'(e.acc));
          chk("out_ai", 64'(out_ai), 64'(e.ai));
          chk("out_count", 64'(out_count), 64'(e.cnt));
        end
        n_popped++;
      end
      if (in_valid && in_ready) begin
        if (!m_open) begin
          m_acc = bias_in + lane_sum(acc_in);
          m_ai  = lane_sum(ai_in);
          m_cnt = 1;
        end else begin
          m_acc = m_acc + lane_sum(acc_in);
          m_ai  = m_ai + lane_sum(ai_in);
          m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        end
        m_open = 1'b1;
        if (in_last) begin
          exp_q.push_back('{acc: m_acc, ai: m_ai, cnt: m_cnt});
          n_pushed++;
          m_open = 1'b0;
        end
      end
    end
  end

  always @(negedge rst) begin
    exp_q.delete();
    m_open = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_beat(input logic [N*BP-1:0] a, input logic [N*BP-1:0] b,
                            input logic [BP-1:0] bias, input logic last);
    int unsigned waited = 0;
    acc_in   = a;
    ai_in    = b;
    bias_in  = bias;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      if (waited > 200) begin
        chk("accept_timeout", 64'(0), 64'(1));
        break;
      end
      tick();
      @(negedge clk);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int unsigned k = 0;
    while (!out_valid && k < 100) begin
      tick();
      k++;
    end
    chk("out_valid_wait", 64'(out_valid), 64'(1));
  endtask

  task automatic drain();
    int unsigned k = 0;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < 200) begin
      tick();
      k++;
    end
    chk("drain", 64'(exp_q.size() == 0 && !out_valid), 64'(1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [N*BP-1:0] va, vb, b1a, b1i, b2a, b2i, b3a, b3i, ones, fives;
    logic [BP-1:0]   snap_acc, snap_ai, bias1, exp_acc, exp_ai;
    logic [CW-1:0]   snap_cnt;
    int unsigned     len;

    ones  = {N{32'd1}};
    fives = {N{32'd5}};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_acc", 64'(out_acc), 64'(0));
    chk("rst_out_ai", 64'(out_ai), 64'(0));
    chk("rst_out_count", 64'(out_count), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    #3 rst = 1'b1;
    tick();

    // Single beat, fixed latency
    va = {32'd4, 32'd3, 32'd2, 32'd1};
    vb = {32'd40, 32'd30, 32'd20, 32'd10};
    drive_beat(va, vb, 32'd100, 1'b1);
    chk("lat_c1", 64'(out_valid), 64'(0));
    tick();
    chk("lat_c2", 64'(out_valid), 64'(0));
    tick();
    chk("lat_c3", 64'(out_valid), 64'(1));
    chk("single_acc", 64'(out_acc), 64'(110));
    chk("single_ai", 64'(out_ai), 64'(100));
    chk("single_cnt", 64'(out_count), 64'(1));
    drain();

    // Three beats, later bias ignored
    vb = {N{32'd2}};
    drive_beat(ones, vb, 32'd5, 1'b0);
    drive_beat(ones, vb, 32'd999, 1'b0);
    drive_beat(ones, vb, 32'd999, 1'b1);
    wait_out();
    chk("three_acc", 64'(out_acc), 64'(17));
    chk("three_ai", 64'(out_ai), 64'(24));
    chk("three_cnt", 64'(out_count), 64'(3));
    drain();

    // Backpressure
    out_ready = 1'b0;
    drive_beat(rand_vec(), rand_vec(), $urandom, 1'b1);
    wait_out();
    snap_acc = out_acc;
    snap_ai  = out_ai;
    snap_cnt = out_count;
    acc_in   = rand_vec();
    ai_in    = rand_vec();
    bias_in  = $urandom;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_hold_valid", 64'(out_valid), 64'(1));
      chk("bp_hold_acc", 64'(out_acc), 64'(snap_acc));
      chk("bp_hold_ai", 64'(out_ai), 64'(snap_ai));
      chk("bp_hold_cnt", 64'(out_count), 64'(snap_cnt));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    wait_out();
    drain();
    chk("bp_no_loss", 64'(n_popped), 64'(n_pushed));

    // Modular wrap
    va = {N{32'hFFFF_FFFF}};
    vb = {N{32'h8000_0000}};
    drive_beat(va, vb, 32'd4, 1'b1);
    wait_out();
    chk("wrap_acc", 64'(out_acc), 64'(0));
    chk("wrap_ai", 64'(out_ai), 64'(0));
    drain();

    // Reset mid-group
    drive_beat(fives, fives, 32'd7, 1'b0);
    drive_beat(fives, fives, 32'd7, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #2;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    #4 rst = 1'b1;
    tick();
    drive_beat(ones, ones, 32'd0, 1'b1);
    wait_out();
    chk("midrst_acc", 64'(out_acc), 64'(4));
    chk("midrst_ai", 64'(out_ai), 64'(4));
    chk("midrst_cnt", 64'(out_count), 64'(1));
    drain();

    // Clock-enable stall inside a group
    b1a = rand_vec(); b1i = rand_vec();
    b2a = rand_vec(); b2i = rand_vec();
    b3a = rand_vec(); b3i = rand_vec();
    bias1 = $urandom;
    drive_beat(b1a, b1i, bias1, 1'b0);
    acc_in   = b2a;
    ai_in    = b2i;
    in_last  = 1'b0;
    in_valid = 1'b1;
    ce       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ce_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    ce = 1'b1;
    drive_beat(b2a, b2i, $urandom, 1'b0);
    drive_beat(b3a, b3i, $urandom, 1'b1);
    wait_out();
    exp_acc = bias1 + lane_sum(b1a) + lane_sum(b2a) + lane_sum(b3a);
    exp_ai  = lane_sum(b1i) + lane_sum(b2i) + lane_sum(b3i);
    chk("ce_acc", 64'(out_acc), 64'(exp_acc));
    chk("ce_ai", 64'(out_ai), 64'(exp_ai));
    chk("ce_cnt", 64'(out_count), 64'(3));
    drain();

    // Randomized groups with bubbles and random backpressure
    rnd_ready = 1'b1;
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, 5);
      for (int unsigned b = 0; b < len; b++) begin
        drive_beat(rand_vec(), rand_vec(), $urandom, b == len - 1);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      end
    end
    drain();
    chk("rnd_result_count", 64'(n_popped), 64'(n_pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
